// File: rtl/inst_buffer_if.sv
// Packet/branch types and the fetch/dispatch-facing bundle of the
// instruction buffer.
package inst_buffer_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } inst_packet_t;

    typedef enum logic [1:0] {
        NOTHING,
        SQUASH,
        PREDICT,
        STALL
    } br_task_t;

endpackage

interface inst_buffer_if #(
    parameter int N               = 3,
    parameter int INST_BUFF_DEPTH = 8
);
    import inst_buffer_pkg::*;

    inst_packet_t [3:0]                           in_insts;
    logic [2:0]                                   in_num_insts;
    br_task_t                                     br_task;
    logic [$clog2(N+1)-1:0]                       dispatch_num;
    inst_packet_t [N-1:0]                         out_insts;
    logic [$clog2(N+1)-1:0]                       out_num_insts;
    logic [$clog2(INST_BUFF_DEPTH+1)-1:0]         ibuff_open;

    modport master (
        output in_insts, in_num_insts, br_task, dispatch_num,
        input  out_insts, out_num_insts, ibuff_open
    );

    modport slave (
        input  in_insts, in_num_insts, br_task, dispatch_num,
        output out_insts, out_num_insts, ibuff_open
    );

endinterface

// File: rtl/inst_buffer.sv
// Circular instruction buffer between fetch and dispatch: up to 4
// packets in per cycle, up to N oldest presented first-word-fall-through.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int N               = 3,
    parameter int INST_BUFF_DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    inst_buffer_if.slave bus
);

    localparam int PW = $clog2(INST_BUFF_DEPTH);
    localparam int CW = $clog2(INST_BUFF_DEPTH + 1);
    localparam int NW = $clog2(N + 1);
    localparam int unsigned DEPTH_U = INST_BUFF_DEPTH;
    localparam int unsigned N_U     = N;

    inst_packet_t         entries [INST_BUFF_DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [CW-1:0]        count;

    int unsigned          open_i;
    int unsigned          onum_i;
    int unsigned          deq_i;
    int unsigned          enq_i;
    int unsigned          req_i;

    // Offsets never exceed DEPTH, so one conditional subtract is a full modulo.
    function automatic logic [PW-1:0] wrap(input int unsigned v);
        int unsigned r;
        r = (v >= DEPTH_U) ? v - DEPTH_U : v;
        return r[PW-1:0];
    endfunction

    always_comb begin
        open_i = DEPTH_U - int'(count);
        onum_i = (int'(count) > N_U) ? N_U : int'(count);
        deq_i  = int'(bus.dispatch_num);
        if (deq_i > onum_i)
            deq_i = onum_i;
        req_i  = int'(bus.in_num_insts);
        enq_i  = (req_i > 4) ? 4 : req_i;
        if (enq_i > open_i)
            enq_i = open_i;
    end

    always_comb begin
        bus.out_insts     = '0;
        bus.ibuff_open    = CW'(open_i);
        bus.out_num_insts = NW'(onum_i);
        for (int unsigned i = 0; i < N_U; i++) begin
            if (i < onum_i)
                bus.out_insts[i] = entries[wrap(int'(head) + i)];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < INST_BUFF_DEPTH; i++)
                entries[i] <= '0;
        end else if (bus.br_task == SQUASH) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            assert (int'(bus.dispatch_num) <= onum_i)
                else $warning("inst_buffer: dispatch_num over-request");
            assert (req_i <= open_i)
                else $warning("inst_buffer: enqueue beyond ibuff_open");
            for (int unsigned k = 0; k < 4; k++) begin
                if (k < enq_i)
                    entries[wrap(int'(tail) + k)] <= bus.in_insts[k];
            end
            head  <= wrap(int'(head) + deq_i);
            tail  <= wrap(int'(tail) + enq_i);
            count <= CW'(int'(count) + enq_i - deq_i);
        end
    end

endmodule
